// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, request-to-send, shift, ack).
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 250,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);
  localparam int M1   = INHIBIT_CYCLES > RTS_CYCLES ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int MAXP = TIMEOUT_CYCLES > M1 ? TIMEOUT_CYCLES : M1;
  localparam int CW   = $clog2(MAXP + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE} state_t;
  state_t        state_q;
  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_prev_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    n_q;
  logic [9:0]    sh_q;
  logic          tx_ready_q, clk_oe_q, dat_oe_q, busy_q, tx_done_q, tx_error_q;
  logic          fall, dat_s, timeout;
  assign fall       = clk_prev_q & ~clk_sync_q[1];
  assign dat_s      = dat_sync_q[1];
  assign timeout    = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign tx_ready   = tx_ready_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign busy       = busy_q;
  assign tx_done    = tx_done_q;
  assign tx_error   = tx_error_q;
  // Lines idle high, so the synchronizer resets to 1 to avoid a false falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
      clk_prev_q <= clk_sync_q[1];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      n_q        <= '0;
      sh_q       <= '0;
      tx_ready_q <= 1'b0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_error_q <= 1'b0;
    end else begin
      tx_done_q  <= 1'b0;
      tx_error_q <= 1'b0;
      cnt_q      <= (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
      case (state_q)
        IDLE: begin
          if (tx_valid && tx_ready_q) begin
            state_q    <= INHIBIT;
            sh_q       <= {1'b1, ~^tx_data, tx_data};
            cnt_q      <= '0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            clk_oe_q   <= 1'b1;
          end else begin
            tx_ready_q <= 1'b1;
          end
        end
        INHIBIT: begin
          if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
            state_q  <= RTS;
            dat_oe_q <= 1'b1;
            cnt_q    <= '0;
          end
        end
        RTS: begin
          if (cnt_q == CW'(RTS_CYCLES - 1)) begin
            state_q  <= SHIFT;
            clk_oe_q <= 1'b0;
            cnt_q    <= '0;
            n_q      <= '0;
          end
        end
        SHIFT: begin
          if (fall) begin
            cnt_q    <= '0;
            dat_oe_q <= ~sh_q[0];
            sh_q     <= {1'b0, sh_q[9:1]};
            n_q      <= n_q + 4'd1;
            if (n_q == 4'd9) state_q <= ACK;
          end else if (timeout) begin
            state_q    <= IDLE;
            dat_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b1;
            tx_error_q <= 1'b1;
          end
        end
        ACK: begin
          if (fall) begin
            cnt_q <= '0;
            if (!dat_s) begin
              state_q <= WAIT_IDLE;
            end else begin
              state_q    <= IDLE;
              busy_q     <= 1'b0;
              tx_ready_q <= 1'b1;
              tx_error_q <= 1'b1;
            end
          end else if (timeout) begin
            state_q    <= IDLE;
            dat_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b1;
            tx_error_q <= 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (clk_sync_q[1] && dat_s) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b1;
            tx_done_q  <= 1'b1;
          end else if (fall) begin
            cnt_q <= '0;
          end else if (timeout) begin
            state_q    <= IDLE;
            dat_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b1;
            tx_error_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          clk_oe_q   <= 1'b0;
          dat_oe_q   <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a simple PS/2 device model on the bus.
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int RTSC = 5;
  localparam int TMO = 200;
  logic clk = 0, reset = 1, tx_valid = 0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_error;
  logic dev_clk = 1, dev_dat = 1;
  logic ps2_clk_in, ps2_dat_in;
  int checks = 0, errors = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_cnt = 0, rts_cnt = 0;
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;
  always #5 clk = ~clk;
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .RTS_CYCLES(RTSC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in), .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe), .busy(busy), .tx_done(tx_done), .tx_error(tx_error));
  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (tx_done && tx_error) both_cnt++;
    if (ps2_clk_oe && !ps2_dat_oe) inh_cnt++;
    if (ps2_clk_oe && ps2_dat_oe) rts_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_valid = 1;
    @(negedge clk);
    tx_valid = 0;
  endtask
  // Device side: clocks nedges falling edges (11 includes the ack edge) and records host bits.
  task automatic dev_run(input int nedges, input bit ack, output logic [10:0] bits);
    int w;
    bits = '0;
    w = 0;
    while (!(busy && !ps2_clk_oe) && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("shift_entry", 32'(w < 100), 1);
    bits[0] = ~ps2_dat_oe;
    repeat (4) @(negedge clk);
    for (int n = 1; n <= nedges && n <= 10; n++) begin
      dev_clk = 0;
      repeat (6) @(negedge clk);
      bits[n] = ~ps2_dat_oe;
      repeat (2) @(negedge clk);
      dev_clk = 1;
      repeat (8) @(negedge clk);
    end
    if (nedges > 10) begin
      dev_dat = ~ack;
      repeat (2) @(negedge clk);
      dev_clk = 0;
      repeat (8) @(negedge clk);
      dev_clk = 1;
      repeat (4) @(negedge clk);
      dev_dat = 1;
      w = 0;
      while (busy && w < 50) begin
        @(negedge clk);
        w++;
      end
      chk("return_idle", 32'(w < 50), 1);
      @(negedge clk);
    end
  endtask
  initial begin
    logic [10:0] bits;
    int d0, e0, i0, r0, k;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_dat_oe", ps2_dat_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tx_ready, 0);
    chk("rst_done_err", {tx_done, tx_error}, 0);
    reset = 0;
    @(negedge clk);
    chk("ready_after_rst", tx_ready, 1);
    // 8'hED with ack
    d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt; r0 = rts_cnt;
    send(8'hED);
    chk("ready_busy", tx_ready, 0);
    chk("busy_set", busy, 1);
    dev_run(11, 1, bits);
    chk("ed_inhibit_cycles", inh_cnt - i0, INH);
    chk("ed_rts_cycles", rts_cnt - r0, RTSC);
    chk("ed_bits", bits, 11'b11111011010);
    chk("ed_done", done_cnt - d0, 1);
    chk("ed_err", err_cnt - e0, 0);
    chk("ed_idle", {busy, tx_ready, ps2_clk_oe, ps2_dat_oe}, 4'b0100);
    // 8'h01 with ack
    d0 = done_cnt; e0 = err_cnt;
    send(8'h01);
    dev_run(11, 1, bits);
    chk("01_bits", bits, 11'b10000000010);
    chk("01_done", done_cnt - d0, 1);
    chk("01_err", err_cnt - e0, 0);
    // 8'hAA with no ack
    d0 = done_cnt; e0 = err_cnt;
    send(8'hAA);
    dev_run(11, 0, bits);
    chk("nack_bits", bits, 11'b11101010100);
    chk("nack_err", err_cnt - e0, 1);
    chk("nack_done", done_cnt - d0, 0);
    chk("nack_idle", {busy, tx_ready, ps2_clk_oe, ps2_dat_oe}, 4'b0100);
    // device never clocks: timeout
    d0 = done_cnt; e0 = err_cnt;
    send(8'h12);
    k = 0;
    while (!(busy && !ps2_clk_oe) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_shift_entry", 32'(k < 100), 1);
    k = 0;
    while (!tx_error && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_latency", k, TMO);
    chk("tmo_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
    chk("tmo_done", done_cnt - d0, 0);
    @(negedge clk);
    chk("tmo_err_once", err_cnt - e0, 1);
    chk("tmo_idle", {busy, tx_ready}, 2'b01);
    // reset after edge 4
    d0 = done_cnt; e0 = err_cnt;
    send(8'h33);
    dev_run(4, 1, bits);
    chk("pre_rst_busy", busy, 1);
    reset = 1;
    @(negedge clk);
    chk("mid_rst_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
    chk("mid_rst_busy_ready", {busy, tx_ready}, 0);
    reset = 0;
    @(negedge clk);
    chk("mid_rst_ready", tx_ready, 1);
    chk("mid_rst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
    send(8'hF4);
    dev_run(11, 1, bits);
    chk("f4_bits", bits, 11'b10111101000);
    chk("f4_done", done_cnt - d0, 1);
    chk("f4_err", err_cnt - e0, 0);
    // tx_valid while busy is ignored
    d0 = done_cnt;
    send(8'hED);
    tx_data = 8'h00;
    tx_valid = 1;
    repeat (3) @(negedge clk);
    chk("busy_ready_low", tx_ready, 0);
    tx_valid = 0;
    dev_run(11, 1, bits);
    chk("busy_ignore_bits", bits, 11'b11111011010);
    chk("busy_ignore_done", done_cnt - d0, 1);
    repeat (30) @(negedge clk);
    chk("busy_no_second", {busy, done_cnt - d0}, 1);
    chk("no_done_err_overlap", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000; clock-low inhibit duration (100 us at 50 MHz).
REQ-002 SHALL have parameter RTS_CYCLES, default 250; duration data and clock are both driven low before clock release.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000; maximum cycles allowed between device clock falling edges (20 ms).
REQ-004 SHALL have port clk, input, 1: the single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port tx_data, input, 8: command byte to send to the keyboard.
REQ-007 SHALL have port tx_valid, input, 1: tx_data is valid.
REQ-008 SHALL have port tx_ready, output, 1: block accepts a byte this cycle.
REQ-009 SHALL have port ps2_clk_in, input, 1: asynchronous PS/2 clock line level.
REQ-010 SHALL have port ps2_dat_in, input, 1: asynchronous PS/2 data line level.
REQ-011 SHALL have port ps2_clk_oe, output, 1: 1 = pull PS/2 clock low; 0 = release.
REQ-012 SHALL have port ps2_dat_oe, output, 1: 1 = pull PS/2 data low; 0 = release.
REQ-013 SHALL have port busy, output, 1: transfer in progress; the receive decoder uses it to ignore the bus.
REQ-014 SHALL have port tx_done, output, 1: one-cycle pulse on an acknowledged transfer.
REQ-015 SHALL have port tx_error, output, 1: one-cycle pulse on a timeout or a missing acknowledge.

Function
REQ-016 SHALL pass ps2_clk_in and ps2_dat_in through a 2-flop synchronizer; a falling edge is synced clock 1 then 0.
REQ-017 SHALL implement these states: IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE.
REQ-018 In IDLE, tx_ready SHALL be 1, busy 0, and both oe outputs 0.
REQ-019 On tx_valid && tx_ready, the block SHALL latch tx_data, compute parity = ~^tx_data (odd parity), and go to INHIBIT.
REQ-020 INHIBIT SHALL drive clk_oe=1, dat_oe=0 for exactly INHIBIT_CYCLES cycles, then go to RTS.
REQ-021 RTS SHALL drive clk_oe=1, dat_oe=1 (start bit 0) for RTS_CYCLES cycles, then go to SHIFT with clk_oe=0 and dat_oe kept at 1.
REQ-022 SHIFT SHALL count device clock falling edges n = 1..10 and drive dat_oe = ~bit, where edges 1-8 carry data bits 0-7 (LSB first), edge 9 carries parity, and edge 10 carries the stop bit (dat_oe=0). It SHALL then go to ACK.
REQ-023 ACK SHALL sample synced data on the 11th falling edge: 0 means acknowledged and the block goes to WAIT_IDLE; 1 means tx_error pulses and the block goes to IDLE.
REQ-024 WAIT_IDLE SHALL wait until synced clock and data are both 1, then pulse tx_done and go to IDLE.
REQ-025 The timeout counter SHALL clear on entry to SHIFT and on every falling edge. In SHIFT, ACK or WAIT_IDLE, reaching TIMEOUT_CYCLES SHALL release both lines, pulse tx_error and return to IDLE.
REQ-026 tx_valid SHALL be ignored while tx_ready=0; no queueing.
REQ-027 busy SHALL be 1 in every state except IDLE; tx_done and tx_error SHALL never assert in the same cycle.
REQ-028 Counters SHALL be sized by $clog2 of the largest parameter and SHALL saturate, never wrap.
REQ-029 A falling edge seen in INHIBIT or RTS SHALL be ignored.

Reset
REQ-030 While reset=1, the block SHALL go to IDLE on the next clk edge with ps2_clk_oe=0, ps2_dat_oe=0, tx_done=0, tx_error=0, busy=0, tx_ready=0, and all counters and the shift register cleared.
REQ-031 tx_ready SHALL become 1 on the first cycle after reset deasserts.
REQ-032 Reset during any state SHALL abort the transfer and release both lines with no done or error pulse.

Verification
REQ-033 Send 8'hED with a device model that acknowledges -> clk_oe low for 5000 cycles; data bits observed 1,0,1,1,0,1,1,1; parity 1; stop released; tx_done pulses once.
REQ-034 Send 8'h01 -> parity bit 0; the bit on edge 1 is 1, edges 2-8 are 0; tx_done pulses.
REQ-035 Device leaves data high on the 11th edge -> tx_error pulses, tx_done stays 0, return to IDLE.
REQ-036 Device never clocks after RTS -> tx_error pulses exactly TIMEOUT_CYCLES after SHIFT entry; both oe outputs 0.
REQ-037 Assert reset in SHIFT after edge 4 -> oe outputs 0 next cycle, no pulses; a following 8'hF4 send completes normally.
REQ-038 Pulse tx_valid while busy -> byte ignored; only the first byte appears on the bus.
